// File: rtl/win_pkg.sv
// Shared constants and window bit-layout helper for the 7x7 window generator.
package win_pkg;

  localparam int unsigned WIN_SIZE = 7;
  localparam int unsigned PIX_W    = 8;
  localparam int unsigned WIN_BITS = WIN_SIZE * WIN_SIZE * PIX_W;
  localparam int unsigned LB_ROWS  = WIN_SIZE - 1;

  // A[0][0] occupies the top byte; elements follow row-major down to A[6][6] at bit 0.
  function automatic int unsigned win_offset(int unsigned i, int unsigned j);
    return WIN_BITS - PIX_W - (i * WIN_SIZE + j) * PIX_W;
  endfunction

endpackage

// File: rtl/window_7x7_gen_if.sv
// Pixel-in / window-out bundle between the raster source and the window generator.
interface window_7x7_gen_if
  import win_pkg::*;
#(
  parameter int unsigned IMG_WIDTH  = 640,
  parameter int unsigned IMG_HEIGHT = 480
) ();

  logic                          pix_valid;
  logic [PIX_W-1:0]              pix_data;
  logic                          pix_sof;
  logic                          win_valid;
  logic [WIN_BITS-1:0]           window_out;
  logic [$clog2(IMG_HEIGHT)-1:0] win_row;
  logic [$clog2(IMG_WIDTH)-1:0]  win_col;
  logic                          frame_done;

  modport master (
    output pix_valid, pix_data, pix_sof,
    input  win_valid, window_out, win_row, win_col, frame_done
  );

  modport slave (
    input  pix_valid, pix_data, pix_sof,
    output win_valid, window_out, win_row, win_col, frame_done
  );

endinterface

// File: rtl/line_buffer_ram.sv
// Six image rows packed side by side in one word per column; async read, sync write.
module line_buffer_ram #(
  parameter int unsigned Depth = 640,
  parameter int unsigned Width = 48,
  parameter int unsigned AddrW = $clog2(Depth)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AddrW-1:0] addr_i,
  input  logic [Width-1:0] wdata_i,
  output logic [Width-1:0] rdata_o
);

  logic [Width-1:0] mem_q [Depth];

  assign rdata_o = mem_q[addr_i];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

endmodule

// File: rtl/window_7x7_gen.sv
// Raster pixel stream to 7x7 sliding window with centre coordinates and frame-done pulse.
module window_7x7_gen
  import win_pkg::*;
#(
  parameter int unsigned IMG_WIDTH  = 640,
  parameter int unsigned IMG_HEIGHT = 480
) (
  input  logic            clk,
  input  logic            rst_n,
  window_7x7_gen_if.slave bus
);

  localparam int unsigned ColW = $clog2(IMG_WIDTH);
  localparam int unsigned RowW = $clog2(IMG_HEIGHT);
  localparam int unsigned LbW  = LB_ROWS * PIX_W;

  logic                accept;
  logic [ColW-1:0]     col_q, col_d, cur_col, wcol_q;
  logic [RowW-1:0]     row_q, row_d, cur_row, wrow_q;
  logic [LbW-1:0]      lb_rdata, lb_wdata;
  logic [WIN_BITS-1:0] win_q, win_d, out_q;
  logic                strobe_d, valid_q, fd_d, fd_q;

  assign accept  = bus.pix_valid;
  // Start-of-frame overrides the counters for the pixel that carries it.
  assign cur_col = (bus.pix_sof) ? '0 : col_q;
  assign cur_row = (bus.pix_sof) ? '0 : row_q;

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (accept) begin
      if (cur_col == ColW'(IMG_WIDTH - 1)) begin
        col_d = '0;
        row_d = (cur_row == RowW'(IMG_HEIGHT - 1)) ? '0 : cur_row + 1'b1;
      end else begin
        col_d = cur_col + 1'b1;
        row_d = cur_row;
      end
    end
  end

  // Vertical shift: each stored row moves up one slot, the new pixel enters the youngest.
  assign lb_wdata = {bus.pix_data, lb_rdata[LbW-1:PIX_W]};

  line_buffer_ram #(
    .Depth (IMG_WIDTH),
    .Width (LbW)
  ) u_lb (
    .clk_i   (clk),
    .we_i    (accept),
    .addr_i  (cur_col),
    .wdata_i (lb_wdata),
    .rdata_o (lb_rdata)
  );

  always_comb begin
    win_d = win_q;
    if (accept) begin
      for (int unsigned i = 0; i < WIN_SIZE; i++) begin
        for (int unsigned j = 0; j < WIN_SIZE - 1; j++) begin
          win_d[win_offset(i, j) +: PIX_W] = win_q[win_offset(i, j + 1) +: PIX_W];
        end
      end
      for (int unsigned i = 0; i < LB_ROWS; i++) begin
        win_d[win_offset(i, WIN_SIZE - 1) +: PIX_W] = lb_rdata[i * PIX_W +: PIX_W];
      end
      win_d[win_offset(WIN_SIZE - 1, WIN_SIZE - 1) +: PIX_W] = bus.pix_data;
    end
  end

  // Border windows (including stale columns after a line wrap) never qualify.
  assign strobe_d = accept && (cur_row >= RowW'(LB_ROWS)) && (cur_col >= ColW'(LB_ROWS));
  assign fd_d     = accept && (cur_row == RowW'(IMG_HEIGHT - 1))
                           && (cur_col == ColW'(IMG_WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q   <= '0;
      row_q   <= '0;
      win_q   <= '0;
      out_q   <= '0;
      wrow_q  <= '0;
      wcol_q  <= '0;
      valid_q <= 1'b0;
      fd_q    <= 1'b0;
    end else begin
      col_q   <= col_d;
      row_q   <= row_d;
      win_q   <= win_d;
      valid_q <= strobe_d;
      fd_q    <= fd_d;
      if (strobe_d) begin
        out_q  <= win_d;
        wrow_q <= cur_row - RowW'(3);
        wcol_q <= cur_col - ColW'(3);
      end
    end
  end

  assign bus.win_valid  = valid_q;
  assign bus.window_out = out_q;
  assign bus.win_row    = wrow_q;
  assign bus.win_col    = wcol_q;
  assign bus.frame_done = fd_q;

endmodule
